// File: rtl/id_stage.sv
// Decode stage: MIPS-style field decode into a one-entry output register with a
// 32-entry write scoreboard. Optional illegal-opcode trap under `ILLEGAL_TRAP_EN.
module id_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_valid,
  input  logic              ex_ready,
  output logic [REG_AW-1:0] operand_1,
  output logic [REG_AW-1:0] operand_2,
  output logic [DATA_W-1:0] destination_reg,
  output logic [3:0]        alu_control,
  output logic              reg_write,
  output logic [15:0]       immediate_value,
  output logic [DATA_W-1:0] id_pc,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              flush,
  output logic              illegal_instr
);

  localparam int NREG = 2 ** REG_AW;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD   = 6'b100000;

  // Handshake: a word moves on a side only in a cycle where its valid and
  // ready are both high; valid never depends on ready on either side.

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              is_add;
  logic              is_addi;
  logic              is_j;
  logic [3:0]        dec_alu;
  logic              dec_rw;
  logic [DATA_W-1:0] dec_dest;
  logic [REG_AW-1:0] dec_dst_idx;

  logic              id_valid_q, id_valid_d;
  logic [REG_AW-1:0] op1_q, op1_d;
  logic [REG_AW-1:0] op2_q, op2_d;
  logic [DATA_W-1:0] dest_q, dest_d;
  logic [3:0]        alu_q, alu_d;
  logic              rw_q, rw_d;
  logic [15:0]       imm_q, imm_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic [NREG-1:0]   pend_clr;
  logic [NREG-1:0]   busy;
  logic              hazard;
  logic              accept;
  logic              transfer;

  always_comb begin
    opcode  = if_instr[31:26];
    funct   = if_instr[5:0];
    rs      = if_instr[21 +: REG_AW];
    rt      = if_instr[16 +: REG_AW];
    rd      = if_instr[11 +: REG_AW];
    is_add  = (opcode == OP_RTYPE) && (funct == FN_ADD);
    is_addi = (opcode == OP_ADDI);
    is_j    = (opcode == OP_J);
    dec_alu  = 4'b0000;
    dec_rw   = 1'b0;
    dec_dest = '0;
    dec_dst_idx = '0;
    if (is_add) begin
      dec_alu     = 4'b0001;
      dec_rw      = 1'b1;
      dec_dst_idx = rd;
      dec_dest[REG_AW-1:0] = rd;
    end else if (is_addi) begin
      dec_alu     = 4'b0010;
      dec_rw      = 1'b1;
      dec_dst_idx = rt;
      dec_dest[REG_AW-1:0] = rt;
    end else if (is_j) begin
      dec_alu        = 4'b0011;
      dec_dest[25:0] = if_instr[25:0];
    end
  end

  // Registers that would cause a hazard: pending after this cycle's writeback
  // clear (bypassed), plus the destination still sitting in the output register.
  always_comb begin
    pend_clr = pending_q;
    if (wb_valid) pend_clr[wb_rd] = 1'b0;
    busy = pend_clr;
    if (id_valid_q && rw_q) busy[dest_q[REG_AW-1:0]] = 1'b1;
    busy[0] = 1'b0;
    hazard = ((is_add || is_addi) && busy[rs]) ||
             (is_add && busy[rt]) ||
             (dec_rw && busy[dec_dst_idx]);
  end

  assign if_ready = rst_n && !flush && !hazard && (!id_valid_q || ex_ready);
  assign accept   = if_valid && if_ready;
  assign transfer = id_valid_q && ex_ready && !flush;

  always_comb begin
    id_valid_d = id_valid_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    dest_d = dest_q;
    alu_d  = alu_q;
    rw_d   = rw_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    if (flush) begin
      id_valid_d = 1'b0;
    end else if (accept) begin
      id_valid_d = 1'b1;
      op1_d  = rs;
      op2_d  = rt;
      dest_d = dec_dest;
      alu_d  = dec_alu;
      rw_d   = dec_rw;
      imm_d  = if_instr[15:0];
      pc_d   = if_pc;
    end else if (transfer) begin
      id_valid_d = 1'b0;
    end
  end

  // Set is applied after the clear so a same-cycle set of the same register wins.
  always_comb begin
    pending_d = pend_clr;
    if (transfer && rw_q) pending_d[dest_q[REG_AW-1:0]] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      dest_q     <= '0;
      alu_q      <= '0;
      rw_q       <= 1'b0;
      imm_q      <= '0;
      pc_q       <= '0;
      pending_q  <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      dest_q     <= dest_d;
      alu_q      <= alu_d;
      rw_q       <= rw_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (flush)       illegal_d = 1'b0;
    else if (accept) illegal_d = !(is_add || is_addi || is_j);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  assign id_valid        = id_valid_q;
  assign operand_1       = op1_q;
  assign operand_2       = op2_q;
  assign destination_reg = dest_q;
  assign alu_control     = alu_q;
  assign reg_write       = rw_q;
  assign immediate_value = imm_q;
  assign id_pc           = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode fields, handshake, scoreboard hazards,
// flush and reset. Expects illegal_instr according to `ILLEGAL_TRAP_EN.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_valid;
  logic        ex_ready;
  logic [4:0]  operand_1;
  logic [4:0]  operand_2;
  logic [31:0] destination_reg;
  logic [3:0]  alu_control;
  logic        reg_write;
  logic [15:0] immediate_value;
  logic [31:0] id_pc;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        illegal_instr;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .id_valid(id_valid), .ex_ready(ex_ready),
    .operand_1(operand_1), .operand_2(operand_2), .destination_reg(destination_reg),
    .alu_control(alu_control), .reg_write(reg_write), .immediate_value(immediate_value),
    .id_pc(id_pc), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    #12;
    check("rst_id_valid", id_valid, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_alu", alu_control, 0);
    check("rst_dest", destination_reg, 0);
    check("rst_rw", reg_write, 0);
    check("rst_pc", id_pc, 0);
    check("rst_illegal", illegal_instr, 0);
    step();
    rst_n = 1'b1;

    // add $3,$1,$2
    if_valid = 1'b1; if_instr = 32'h0022_1820; if_pc = 32'h100;
    settle();
    check("add_if_ready", if_ready, 1);
    step();
    if_valid = 1'b0;
    check("add_id_valid", id_valid, 1);
    check("add_alu", alu_control, 4'b0001);
    check("add_op1", operand_1, 1);
    check("add_op2", operand_2, 2);
    check("add_dest", destination_reg, 3);
    check("add_rw", reg_write, 1);
    check("add_imm", immediate_value, 16'h1820);
    check("add_pc", id_pc, 32'h100);
    step();
    check("add_xfer_valid", id_valid, 0);
    // add $7,$3,$0 probes pending[3]
    if_valid = 1'b1; if_instr = 32'h0060_3820;
    settle();
    check("pend3_hazard", if_ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd3;
    settle();
    check("pend3_wb_bypass", if_ready, 1);
    if_valid = 1'b0;
    step();
    wb_valid = 1'b0;

    // addi $5,$1,0x1212 then dependent add $6,$5,$1
    if_valid = 1'b1; if_instr = 32'h2025_1212; if_pc = 32'h104;
    settle();
    check("addi_if_ready", if_ready, 1);
    step();
    check("addi_alu", alu_control, 4'b0010);
    check("addi_dest", destination_reg, 5);
    check("addi_op1", operand_1, 1);
    check("addi_imm", immediate_value, 16'h1212);
    if_instr = 32'h00A1_3020; if_pc = 32'h108;
    settle();
    check("raw_held_stall", if_ready, 0);
    step();
    check("raw_xfer_valid", id_valid, 0);
    check("raw_pending_stall", if_ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    settle();
    check("raw_wb_release", if_ready, 1);
    step();
    wb_valid = 1'b0; if_valid = 1'b0;
    check("dep_add_valid", id_valid, 1);
    check("dep_add_alu", alu_control, 4'b0001);
    check("dep_add_dest", destination_reg, 6);
    check("dep_add_op1", operand_1, 5);
    check("dep_add_pc", id_pc, 32'h108);
    // transfer sets pending[6] while wb clears 6: set wins
    wb_valid = 1'b1; wb_rd = 5'd6;
    step();
    wb_valid = 1'b0;
    if_valid = 1'b1; if_instr = 32'h00C0_4020;
    settle();
    check("set_wins_hazard", if_ready, 0);
    // WAW: addi $6,$0,1 targets pending $6
    if_instr = 32'h2006_0001;
    settle();
    check("waw_hazard", if_ready, 0);
    if_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd6;
    step();
    wb_valid = 1'b0;

    // j 0x21
    if_valid = 1'b1; if_instr = 32'h0800_0021; if_pc = 32'h10C;
    settle();
    check("j_if_ready", if_ready, 1);
    step();
    check("j_alu", alu_control, 4'b0011);
    check("j_dest", destination_reg, 32'h21);
    check("j_rw", reg_write, 0);

    // stall with ex_ready=0 for three cycles
    ex_ready = 1'b0; if_instr = 32'h2025_1212; if_pc = 32'h110;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_if_ready", if_ready, 0);
      step();
      check("stall_valid", id_valid, 1);
      check("stall_alu", alu_control, 4'b0011);
      check("stall_dest", destination_reg, 32'h21);
      check("stall_pc", id_pc, 32'h10C);
    end
    ex_ready = 1'b1;
    settle();
    check("release_if_ready", if_ready, 1);
    step();
    if_valid = 1'b0;
    check("release_valid", id_valid, 1);
    check("release_alu", alu_control, 4'b0010);
    check("release_pc", id_pc, 32'h110);

    // flush the held addi while ex_ready=1
    flush = 1'b1;
    settle();
    check("flush_if_ready", if_ready, 0);
    step();
    flush = 1'b0;
    check("flush_valid", id_valid, 0);
    if_valid = 1'b1; if_instr = 32'h00A1_3020;
    settle();
    check("flush_no_pend5", if_ready, 1);

    // illegal encodings
    if_instr = 32'hFC00_0000;
    step();
    check("ill_op_alu", alu_control, 0);
    check("ill_op_rw", reg_write, 0);
    check("ill_op_flag", illegal_instr, TRAP);
    if_instr = 32'h0022_1822;
    step();
    check("ill_fn_alu", alu_control, 0);
    check("ill_fn_flag", illegal_instr, TRAP);
    if_instr = 32'h0022_1820;
    step();
    if_valid = 1'b0;
    check("legal_alu", alu_control, 4'b0001);
    check("legal_clears_flag", illegal_instr, 0);
    step();

    // reset while stalled clears output and scoreboard (pending[3] is set)
    ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h2025_1212;
    step();
    if_valid = 1'b0;
    check("pre_rst_valid", id_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", id_valid, 0);
    check("midrst_alu", alu_control, 0);
    check("midrst_if_ready", if_ready, 0);
    step();
    rst_n = 1'b1; ex_ready = 1'b1;
    if_valid = 1'b1; if_instr = 32'h0060_3820;
    settle();
    check("rst_cleared_pend3", if_ready, 1);
    if_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction decode stage. Sits between fetch and the execute stage, and produces exactly the field set the execute stage consumes: operand_1, operand_2, destination_reg, alu_control, reg_write and immediate_value.
- Decodes a 32-bit MIPS-style word and holds the result in a one-entry output pipeline register with valid/ready handshakes on both sides.
- Tracks in-flight register writes in a 32-entry scoreboard and stalls on RAW and WAW hazards.

Parameters:
DATA_W, 32, instruction and PC width
REG_AW, 5, register index width (the scoreboard has 2**REG_AW entries)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  decode accepts the instruction this cycle
if_instr  in  DATA_W  instruction word
if_pc  in  DATA_W  PC of the instruction
id_valid  out  1  decoded instruction valid toward execute
ex_ready  in  1  execute accepts the decoded instruction
operand_1  out  REG_AW  source register rs
operand_2  out  REG_AW  source register rt
destination_reg  out  DATA_W  destination or jump target
alu_control  out  4  operation code
reg_write  out  1  instruction writes a register
immediate_value  out  16  instr[15:0]
id_pc  out  DATA_W  PC carried along with the instruction
wb_valid  in  1  writeback retires a register write
wb_rd  in  REG_AW  register retired by writeback
flush  in  1  discard the held instruction
illegal_instr  out  1  see Optional Feature

Behaviour:
- Reset (async, rst_n=0):
  - id_valid=0; all decoded outputs, id_pc and illegal_instr are 0.
  - All scoreboard pending bits are cleared.
  - if_ready is 0 while rst_n=0.
- Field decode: opcode=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
  - opcode 000000 with funct 100000 (add): alu_control=0001, reg_write=1, destination_reg={27'b0,rd}. Sources are rs and rt.
  - opcode 001000 (addi): alu_control=0010, reg_write=1, destination_reg={27'b0,rt}. Source is rs only.
  - opcode 000010 (j): alu_control=0011, reg_write=0, destination_reg={6'b0,instr[25:0]}. No sources.
  - Any other opcode: NOP, i.e. alu_control=0000 and reg_write=0.
  - operand_1=rs, operand_2=rt and immediate_value=instr[15:0] are always driven, whatever the opcode.
- Latency and throughput: 1 cycle from accept (if_valid && if_ready) to id_valid=1. Throughput is 1 instruction per cycle when there is no hazard.
- Handshake:
  - if_ready = !flush && !hazard && (!id_valid || ex_ready).
  - On accept, the output register loads the decode and id_valid becomes 1.
  - id_valid=1 while ex_ready=0: all outputs are held stable.
  - Transfer to execute happens when id_valid && ex_ready and nothing new is accepted; id_valid then drops to 0.
- Scoreboard (one pending bit per register):
  - Set: pending[destination_reg[4:0]] is set on a transfer with reg_write=1 and destination != 0.
  - Clear: wb_valid clears pending[wb_rd].
  - Same-cycle set and clear of the same register: the set wins.
  - Register 0 is never marked pending.
- Hazard (combinational, evaluated on the incoming if_instr):
  - A hazard exists if any source, or the destination of a reg_write instruction, is either:
    - pending after this cycle's wb clear has been applied (the clear is bypassed), or
    - the destination of a held id_valid instruction with reg_write=1.
  - Register 0 never causes a hazard.
- Flush:
  - id_valid goes to 0 on the next edge and nothing is accepted that cycle.
  - The scoreboard is untouched: a flushed instruction was never issued, so its bit was never set.
- Simultaneous flush and ex_ready: flush wins and no transfer occurs (no scoreboard set).
- Reset mid-stall: all state returns to reset values at once.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An unsupported opcode, or opcode 000000 with funct != 100000, is decoded as NOP and loads illegal_instr=1 alongside it.
  - illegal_instr is cleared whenever a legal instruction loads, on flush, and on reset.
- Undefined: illegal_instr is tied to 0 and illegal encodings are silent NOPs.

Test Plan:
1. Issue 0x00221820 (add $3,$1,$2) with ex_ready=1 -> next cycle id_valid=1, alu_control=0001, operand_1=1, operand_2=2, destination_reg=3, reg_write=1; pending[3] is set after the transfer.
2. Issue 0x20251212 (addi $5,$1,0x1212), then 0x00A13020 (add $6,$5,$1) with wb_valid=0 -> if_ready=0 for the second instruction. Pulse wb_valid with wb_rd=5 -> it is accepted that same cycle.
3. Issue 0x08000021 (j) -> alu_control=0011, destination_reg=0x21, reg_write=0; no scoreboard change.
4. Hold ex_ready=0 for 3 cycles with id_valid=1 -> all outputs stable and if_ready=0. Release -> transfer and accept in the same cycle.
5. Assert flush while an addi is held and ex_ready=1 -> id_valid=0 next cycle and pending[5] stays 0.
6. With ILLEGAL_TRAP_EN defined, issue 0xFC000000 -> alu_control=0000, reg_write=0, illegal_instr=1. Without the macro -> illegal_instr=0.
